// File: rtl/i2c_tx_fifo.sv
// Transmit FIFO between the APB register block and the I2C core, plus the FIFO status byte.
// Define I2C_TX_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module i2c_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en_i,
  input  logic                  clr_sticky_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic [7:0]            status_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         count_q;
  logic                  ovf_q;
  logic                  udf_q;

  logic full_c;
  logic empty_c;
  logic afull_c;
  logic aempty_c;
  logic rd_acc_c;
  logic wr_acc_c;
  logic ovf_evt_c;
  logic udf_evt_c;

  // Accept logic: a write into a full FIFO succeeds only when a read frees a slot that cycle
  always_comb begin
    full_c    = (count_q == PW'(DEPTH));
    empty_c   = (count_q == '0);
    afull_c   = (count_q >= PW'(AF_LEVEL));
    aempty_c  = (count_q <= PW'(AE_LEVEL));
    rd_acc_c  = rd_en_i & ~empty_c;
    wr_acc_c  = wr_en_i & (~full_c | rd_acc_c);
    ovf_evt_c = wr_en_i & full_c & ~rd_acc_c;
    udf_evt_c = rd_en_i & empty_c;
  end

  // Storage array, intentionally not reset
  always_ff @(posedge pclk_i) begin
    if (!preset_i && wr_acc_c) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_acc_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a fresh event beats a clear in the same cycle
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_evt_c)         ovf_q <= 1'b1;
      else if (clr_sticky_i) ovf_q <= 1'b0;
      if (udf_evt_c)         udf_q <= 1'b1;
      else if (clr_sticky_i) udf_q <= 1'b0;
    end
  end

`ifdef I2C_TX_FIFO_FWFT_EN
  assign data_o       = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign data_valid_o = ~empty_c;
`else
  // Registered read: one-cycle latency, data held until the next accepted read
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= rd_acc_c;
      if (rd_acc_c) data_o <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end
`endif

  assign count_o  = count_q;
  assign status_o = {2'b00, udf_q, ovf_q, afull_c, aempty_c, full_c, empty_c};

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Directed self-checking bench for i2c_tx_fifo in registered-read mode.
module tb_i2c_tx_fifo;

  logic       pclk_i = 1'b0;
  logic       preset_i;
  logic       wr_en_i;
  logic [7:0] data_i;
  logic       rd_en_i;
  logic       clr_sticky_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic [4:0] count_o;
  logic [7:0] status_o;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  i2c_tx_fifo dut (
    .pclk_i       (pclk_i),
    .preset_i     (preset_i),
    .wr_en_i      (wr_en_i),
    .data_i       (data_i),
    .rd_en_i      (rd_en_i),
    .clr_sticky_i (clr_sticky_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .count_o      (count_o),
    .status_o     (status_o)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1ns after the edge
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en_i      = w;
    data_i       = d;
    rd_en_i      = r;
    clr_sticky_i = c;
    @(posedge pclk_i);
    #1;
    wr_en_i      = 1'b0;
    rd_en_i      = 1'b0;
    clr_sticky_i = 1'b0;
  endtask

  initial begin
    preset_i = 1'b0; wr_en_i = 1'b0; data_i = '0; rd_en_i = 1'b0; clr_sticky_i = 1'b0;

    // 1. Reset with a write strobe held high
    preset_i = 1'b1;
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    preset_i = 1'b0;
    check("rst_count",  32'(count_o), 32'd0);
    check("rst_status", 32'(status_o), 32'h05);
    check("rst_valid",  32'(data_valid_o), 32'd0);
    check("rst_data",   32'(data_o), 32'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_nothing_stored", 32'(count_o), 32'd0);

    // 2. Single byte
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    check("single_count",  32'(count_o), 32'd1);
    check("single_status", 32'(status_o), 32'h04);
    check("single_novalid", 32'(data_valid_o), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("single_data",  32'(data_o), 32'h3C);
    check("single_valid", 32'(data_valid_o), 32'd1);
    check("single_empty", 32'(status_o), 32'h05);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_valid_drop", 32'(data_valid_o), 32'd0);
    check("single_data_hold",  32'(data_o), 32'h3C);

    // 3. Fill and overflow
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_count",  32'(count_o), 32'd16);
    check("fill_status", 32'(status_o), 32'h1A);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check($sformatf("fill_pop%0d", i), 32'(data_o), 32'(i));
      check($sformatf("fill_valid%0d", i), 32'(data_valid_o), 32'd1);
      if (i == 3) check("fill_af_at12", 32'(status_o), 32'h18);
      if (i == 4) check("fill_mid_at11", 32'(status_o), 32'h10);
    end
    check("drain_status", 32'(status_o), 32'h15);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clear", 32'(status_o), 32'h05);

    // 4. Underflow and clear
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set",   32'(status_o), 32'h25);
    check("udf_count", 32'(count_o), 32'd0);
    check("udf_novalid", 32'(data_valid_o), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("udf_clear", 32'(status_o), 32'h05);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    check("udf_event_wins", 32'(status_o), 32'h25);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("udf_clear2", 32'(status_o), 32'h05);

    // 5. Simultaneous push/pop at full and at empty
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    check("sim_full_count", 32'(count_o), 32'd16);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    check("sim_full_count_after", 32'(count_o), 32'd16);
    check("sim_full_no_ovf", 32'(status_o), 32'h0A);
    check("sim_full_pop", 32'(data_o), 32'h80);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check($sformatf("sim_pop%0d", i), 32'(data_o), 32'(8'h80 + i));
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("sim_last_55", 32'(data_o), 32'h55);
    check("sim_empty", 32'(status_o), 32'h05);
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    check("sim_empty_count", 32'(count_o), 32'd1);
    check("sim_empty_status", 32'(status_o), 32'h24);
    check("sim_empty_novalid", 32'(data_valid_o), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    check("sim_empty_data", 32'(data_o), 32'h66);
    check("sim_empty_clr", 32'(status_o), 32'h05);

    // 6. Wrap-around with interleaved push/pop, then thresholds
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 8'(8'hC2 + k), 1'b1, 1'b0);
      check($sformatf("wrap_data%0d", k), 32'(data_o), 32'(8'(8'hC0 + k)));
      check($sformatf("wrap_count%0d", k), 32'(count_o), 32'd2);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_tail0", 32'(data_o), 32'(8'hC0 + 8'd40));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_tail1", 32'(data_o), 32'(8'hC0 + 8'd41));
    check("wrap_empty", 32'(status_o), 32'h05);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 4)  check("ae_at4",  32'(status_o[2]), 32'd1);
      if (i == 5)  check("ae_at5",  32'(status_o[2]), 32'd0);
      if (i == 11) check("af_at11", 32'(status_o[3]), 32'd0);
      if (i == 12) check("af_at12", 32'(status_o[3]), 32'd1);
    end
    check("thr_count", 32'(count_o), 32'd12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
